// File: rtl/sdram_traffic_gen_if.sv
// User-side bus between the SDRAM traffic generator and the SDRAM controller.
// The master side (traffic generator) issues burst requests and write data.
// The slave side (controller) returns per-word acks and read data.
interface sdram_traffic_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [9:0]        wr_burst_len;
  logic [DATA_W-1:0] sdram_wr_data;
  logic              sdram_wr_ack;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [9:0]        rd_burst_len;
  logic [DATA_W-1:0] sdram_rd_data;
  logic              sdram_rd_ack;

  modport master (
    output sdram_wr_req,
    output sdram_wr_addr,
    output wr_burst_len,
    output sdram_wr_data,
    input  sdram_wr_ack,
    output sdram_rd_req,
    output sdram_rd_addr,
    output rd_burst_len,
    input  sdram_rd_data,
    input  sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req,
    input  sdram_wr_addr,
    input  wr_burst_len,
    input  sdram_wr_data,
    output sdram_wr_ack,
    input  sdram_rd_req,
    input  sdram_rd_addr,
    input  rd_burst_len,
    output sdram_rd_data,
    output sdram_rd_ack
  );
endinterface

// File: rtl/sdram_traffic_gen.sv
// SDRAM traffic generator / checker.
// Writes NUM_BURSTS bursts of a deterministic word pattern, reading each burst
// back right after it is written and comparing on the fly. Reports pass/fail,
// a saturating mismatch count, the first failing word address, and a sticky
// flag for acks that arrive outside their phase.
module sdram_traffic_gen #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 24,
  parameter int                BURST_LEN  = 10,
  parameter int                NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
  parameter int                PATTERN    = 0,
  parameter int                CONTINUOUS = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic                init_end,
  sdram_traffic_gen_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                proto_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WRITE     = 3'd2,
    S_WR_GAP    = 3'd3,
    S_READ      = 3'd4,
    S_RD_GAP    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [9:0]  BURST_LEN_C  = 10'(BURST_LEN);
  localparam logic [15:0] LAST_BURST_C = 16'(NUM_BURSTS - 1);

  // Word pattern for global word index k (already reduced mod 2^DATA_W).
  function automatic logic [DATA_W-1:0] pattern_f(input logic [DATA_W-1:0] k);
    logic [DATA_W-1:0] p;
    if (PATTERN == 1) begin
      p = ~k;
    end else begin
      p = k;
    end
    return p;
  endfunction

  state_t            state_r;
  logic [15:0]       b_r;          // burst index within the run
  logic [9:0]        w_r;          // word index within the burst
  logic [DATA_W-1:0] kbase_r;      // global word index of word 0 of burst b
  logic [ADDR_W-1:0] addr_r;       // start address of burst b
  logic              wr_req_r;
  logic              rd_req_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic [15:0]       err_cnt_r;
  logic [ADDR_W-1:0] first_err_addr_r;
  logic              proto_err_r;

  logic [DATA_W-1:0] word_k_s;
  logic [DATA_W-1:0] exp_data_s;
  logic [DATA_W-1:0] nxt_wr_data_s;
  logic [DATA_W-1:0] nxt_kbase_s;
  logic              rd_mis_s;
  logic              last_word_s;
  logic              last_burst_s;
  logic              proto_ev_s;
  logic              launch_s;

  // Pattern arithmetic for the current word and the word that follows it.
  always_comb begin
    word_k_s      = kbase_r + DATA_W'(w_r);
    exp_data_s    = pattern_f(word_k_s);
    nxt_wr_data_s = pattern_f(word_k_s + DATA_W'(1'b1));
    nxt_kbase_s   = kbase_r + DATA_W'(BURST_LEN);
    rd_mis_s      = (bus.sdram_rd_data != exp_data_s);
    last_word_s   = (w_r == (BURST_LEN_C - 10'd1));
    last_burst_s  = (b_r == LAST_BURST_C);
  end

  // An ack is a protocol error unless it arrives in its own data phase.
  always_comb begin
    proto_ev_s = 1'b0;
    if (bus.sdram_wr_ack && (state_r != S_WRITE)) begin
      proto_ev_s = 1'b1;
    end else if (bus.sdram_rd_ack && (state_r != S_READ)) begin
      proto_ev_s = 1'b1;
    end else begin
      proto_ev_s = 1'b0;
    end
  end

  // A run starts from IDLE on start, or from DONE on start / automatically.
  always_comb begin
    launch_s = 1'b0;
    if (state_r == S_IDLE) begin
      launch_s = start;
    end else if (state_r == S_DONE) begin
      launch_s = (CONTINUOUS != 0) ? 1'b1 : start;
    end else begin
      launch_s = 1'b0;
    end
  end

  // Main sequencer: burst/word counters, requests, data and run statistics.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r          <= S_IDLE;
      b_r              <= 16'd0;
      w_r              <= 10'd0;
      kbase_r          <= {DATA_W{1'b0}};
      addr_r           <= {ADDR_W{1'b0}};
      wr_req_r         <= 1'b0;
      rd_req_r         <= 1'b0;
      wr_data_r        <= {DATA_W{1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_cnt_r        <= 16'd0;
      first_err_addr_r <= {ADDR_W{1'b0}};
      proto_err_r      <= 1'b0;
    end else begin
      if (launch_s) begin
        state_r          <= S_WAIT_INIT;
        b_r              <= 16'd0;
        w_r              <= 10'd0;
        kbase_r          <= {DATA_W{1'b0}};
        addr_r           <= BASE_ADDR;
        busy_r           <= 1'b1;
        done_r           <= 1'b0;
        pass_r           <= 1'b0;
        err_cnt_r        <= 16'd0;
        first_err_addr_r <= {ADDR_W{1'b0}};
        proto_err_r      <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            state_r <= S_IDLE;
          end
          S_WAIT_INIT: begin
            if (init_end) begin
              state_r   <= S_WRITE;
              wr_req_r  <= 1'b1;
              wr_data_r <= pattern_f(kbase_r);
            end
          end
          S_WRITE: begin
            if (bus.sdram_wr_ack) begin
              if (last_word_s) begin
                wr_req_r <= 1'b0;
                w_r      <= 10'd0;
                state_r  <= S_WR_GAP;
              end else begin
                w_r       <= w_r + 10'd1;
                wr_data_r <= nxt_wr_data_s;
              end
            end
          end
          S_WR_GAP: begin
            rd_req_r <= 1'b1;
            state_r  <= S_READ;
          end
          S_READ: begin
            if (bus.sdram_rd_ack) begin
              if (rd_mis_s) begin
                if (err_cnt_r == 16'd0) begin
                  first_err_addr_r <= addr_r + ADDR_W'(w_r);
                end
                if (err_cnt_r != 16'hFFFF) begin
                  err_cnt_r <= err_cnt_r + 16'd1;
                end
              end
              if (last_word_s) begin
                rd_req_r <= 1'b0;
                w_r      <= 10'd0;
                state_r  <= S_RD_GAP;
              end else begin
                w_r <= w_r + 10'd1;
              end
            end
          end
          S_RD_GAP: begin
            if (last_burst_s) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (err_cnt_r == 16'd0) && !proto_err_r && !proto_ev_s;
            end else begin
              b_r       <= b_r + 16'd1;
              kbase_r   <= nxt_kbase_s;
              addr_r    <= addr_r + ADDR_W'(BURST_LEN);
              wr_req_r  <= 1'b1;
              wr_data_r <= pattern_f(nxt_kbase_s);
              state_r   <= S_WRITE;
            end
          end
          S_DONE: begin
            pass_r <= (err_cnt_r == 16'd0) && !proto_err_r && !proto_ev_s;
          end
          default: begin
            state_r  <= S_IDLE;
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
          end
        endcase
      end
      if (proto_ev_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign bus.sdram_wr_req  = wr_req_r;
  assign bus.sdram_wr_addr = addr_r;
  assign bus.wr_burst_len  = BURST_LEN_C;
  assign bus.sdram_wr_data = wr_data_r;
  assign bus.sdram_rd_req  = rd_req_r;
  assign bus.sdram_rd_addr = addr_r;
  assign bus.rd_burst_len  = BURST_LEN_C;

  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_cnt        = err_cnt_r;
  assign first_err_addr = first_err_addr_r;
  assign proto_err      = proto_err_r;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench for sdram_traffic_gen: a loopback SDRAM model answers the
// generator's bursts; expected data/addresses are the hand-derived word
// indices of the test plan.
module tb_sdram_traffic_gen;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst;
  logic        start, start2, init_end;
  logic        busy1, done1, pass1, proto1;
  logic [15:0] err_cnt1;
  logic [23:0] first_err1;
  logic        busy2, done2, pass2, proto2;
  logic [15:0] err_cnt2;
  logic [23:0] first_err2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem  [0:255];
  logic [15:0] mem2 [0:15];

  sdram_traffic_gen_if #(.DATA_W(16), .ADDR_W(24)) bus1 ();
  sdram_traffic_gen_if #(.DATA_W(16), .ADDR_W(24)) bus2 ();

  sdram_traffic_gen dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .start          (start),
    .init_end       (init_end),
    .bus            (bus1),
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
    .err_cnt        (err_cnt1),
    .first_err_addr (first_err1),
    .proto_err      (proto1)
  );

  sdram_traffic_gen #(.BURST_LEN(4), .NUM_BURSTS(1), .PATTERN(1)) dut2 (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .start          (start2),
    .init_end       (init_end),
    .bus            (bus2),
    .busy           (busy2),
    .done           (done2),
    .pass           (pass2),
    .err_cnt        (err_cnt2),
    .first_err_addr (first_err2),
    .proto_err      (proto2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // Loopback controller for dut. wr_every: ack every Nth request cycle;
  // flip_addr: word address whose read data gets bit0 inverted (-1 = none);
  // spur: one rd_ack during WRITE; poke: start/init_end disturbance mid-run;
  // abort_rn: leave after this many read acks (-1 = run to done).
  task automatic serve1(input int wr_every, input int flip_addr, input bit spur,
                        input bit poke, input int abort_rn,
                        output int wn, output int rn);
    int cyc, wcnt, low_cnt;
    bit prev_wr, in_gap, spur_done;
    logic [15:0] d;
    logic [23:0] a;
    cyc = 0; wn = 0; rn = 0; wcnt = 0; low_cnt = 0;
    prev_wr = 1'b0; in_gap = 1'b0; spur_done = 1'b0;
    while (done1 !== 1'b1 && cyc < 3000 && !(abort_rn >= 0 && rn >= abort_rn)) begin
      @(negedge sys_clk);
      cyc++;
      bus1.sdram_wr_ack  = 1'b0;
      bus1.sdram_rd_ack  = 1'b0;
      bus1.sdram_rd_data = 16'h0000;
      if (poke) begin
        start    = (cyc == 20);
        init_end = !(cyc >= 30 && cyc < 40);
      end
      chk("req_exclusive", {31'd0, bus1.sdram_wr_req & bus1.sdram_rd_req}, 32'd0);
      if (prev_wr && !bus1.sdram_wr_req) begin
        chk("wr_req_drop_on_last_ack", wn % 10, 0);
        in_gap  = 1'b1;
        low_cnt = 0;
      end
      if (in_gap) begin
        if (bus1.sdram_rd_req) begin
          chk("wr_to_rd_gap_cycles", low_cnt, 1);
          in_gap = 1'b0;
        end else begin
          low_cnt++;
        end
      end
      prev_wr = bus1.sdram_wr_req;
      if (bus1.sdram_wr_req) begin
        chk("wr_addr", {8'd0, bus1.sdram_wr_addr}, (wn / 10) * 10);
        chk("wr_data", {16'd0, bus1.sdram_wr_data}, wn);
        if ((wcnt % wr_every) == (wr_every - 1)) begin
          bus1.sdram_wr_ack = 1'b1;
          a = bus1.sdram_wr_addr + 24'(wn % 10);
          mem[a[7:0]] = bus1.sdram_wr_data;
          wn++;
        end
        wcnt++;
        if (spur && !spur_done && wn == 5) begin
          bus1.sdram_rd_ack = 1'b1;
          spur_done = 1'b1;
        end
      end
      if (bus1.sdram_rd_req) begin
        chk("rd_addr", {8'd0, bus1.sdram_rd_addr}, (rn / 10) * 10);
        a = bus1.sdram_rd_addr + 24'(rn % 10);
        d = mem[a[7:0]];
        if (a == 24'(flip_addr)) d[0] = ~d[0];
        bus1.sdram_rd_ack  = 1'b1;
        bus1.sdram_rd_data = d;
        rn++;
      end
    end
    if (start !== 1'b0) start = 1'b0;
    if (init_end !== 1'b1) init_end = 1'b1;
  endtask

  task automatic check_run(input string tag, input int wn, input int rn,
                           input bit exp_pass, input int exp_err,
                           input int exp_first, input bit exp_proto);
    chk({tag, "_done"}, {31'd0, done1}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, "_acks"}, wn + rn, 80);
    chk({tag, "_pass"}, {31'd0, pass1}, {31'd0, exp_pass});
    chk({tag, "_err_cnt"}, {16'd0, err_cnt1}, exp_err);
    chk({tag, "_first_err_addr"}, {8'd0, first_err1}, exp_first);
    chk({tag, "_proto_err"}, {31'd0, proto1}, {31'd0, exp_proto});
  endtask

  initial begin
    int wn, rn;
    logic [15:0] exp2 [0:3];
    exp2[0] = 16'hFFFF; exp2[1] = 16'hFFFE; exp2[2] = 16'hFFFD; exp2[3] = 16'hFFFC;

    sys_rst = 1'b1; start = 1'b0; start2 = 1'b0; init_end = 1'b0;
    bus1.sdram_wr_ack = 1'b0; bus1.sdram_rd_ack = 1'b0; bus1.sdram_rd_data = 16'h0000;
    bus2.sdram_wr_ack = 1'b0; bus2.sdram_rd_ack = 1'b0; bus2.sdram_rd_data = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;

    // Reset values
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_wr_req", {31'd0, bus1.sdram_wr_req}, 32'd0);
    chk("rst_rd_req", {31'd0, bus1.sdram_rd_req}, 32'd0);
    chk("rst_wr_data", {16'd0, bus1.sdram_wr_data}, 32'd0);
    chk("rst_busy_done_pass", {29'd0, busy1, done1, pass1}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt1}, 32'd0);
    chk("rst_proto_err", {31'd0, proto1}, 32'd0);
    chk("rst_wr_burst_len", {22'd0, bus1.wr_burst_len}, 32'd10);
    chk("rst_rd_burst_len", {22'd0, bus1.rd_burst_len}, 32'd10);
    chk("rst_dut2_burst_len", {22'd0, bus2.wr_burst_len}, 32'd4);

    // Run A: start before init_end, then plain loopback
    pulse_start();
    repeat (3) @(negedge sys_clk);
    chk("A_wait_init_busy", {31'd0, busy1}, 32'd1);
    chk("A_wait_init_no_req", {31'd0, bus1.sdram_wr_req}, 32'd0);
    init_end = 1'b1;
    serve1(1, -1, 1'b0, 1'b0, -1, wn, rn);
    check_run("A", wn, rn, 1'b1, 0, 0, 1'b0);
    repeat (5) @(negedge sys_clk);
    chk("A_done_held", {31'd0, done1}, 32'd1);

    // Run B: bit0 flip on word 23 (burst 2, w=3)
    pulse_start();
    serve1(1, 23, 1'b0, 1'b0, -1, wn, rn);
    check_run("B", wn, rn, 1'b0, 1, 23, 1'b0);

    // Run C: write ack every 3rd cycle, start while busy, init_end dropout
    pulse_start();
    serve1(3, -1, 1'b0, 1'b1, -1, wn, rn);
    check_run("C", wn, rn, 1'b1, 0, 0, 1'b0);

    // Run D: spurious rd_ack during WRITE
    pulse_start();
    serve1(1, -1, 1'b1, 1'b0, -1, wn, rn);
    check_run("D", wn, rn, 1'b0, 0, 0, 1'b1);

    // Run E: asynchronous reset mid-READ, then a full rerun
    pulse_start();
    serve1(1, -1, 1'b0, 1'b0, 15, wn, rn);
    chk("E_mid_read", {31'd0, bus1.sdram_rd_req}, 32'd1);
    bus1.sdram_wr_ack = 1'b0;
    bus1.sdram_rd_ack = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    chk("E_rst_rd_req", {31'd0, bus1.sdram_rd_req}, 32'd0);
    chk("E_rst_rd_addr", {8'd0, bus1.sdram_rd_addr}, 32'd0);
    chk("E_rst_wr_data", {16'd0, bus1.sdram_wr_data}, 32'd0);
    chk("E_rst_busy", {31'd0, busy1}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pulse_start();
    serve1(1, -1, 1'b0, 1'b0, -1, wn, rn);
    check_run("F", wn, rn, 1'b1, 0, 0, 1'b0);

    // dut2: PATTERN=1, BURST_LEN=4, NUM_BURSTS=1
    @(negedge sys_clk);
    start2 = 1'b1;
    @(negedge sys_clk);
    start2 = 1'b0;
    wn = 0; rn = 0;
    for (int c = 0; c < 200 && done2 !== 1'b1; c++) begin
      @(negedge sys_clk);
      bus2.sdram_wr_ack = 1'b0;
      bus2.sdram_rd_ack = 1'b0;
      if (bus2.sdram_wr_req) begin
        chk("P1_wr_data", {16'd0, bus2.sdram_wr_data}, {16'd0, exp2[wn % 4]});
        mem2[wn % 16] = bus2.sdram_wr_data;
        bus2.sdram_wr_ack = 1'b1;
        wn++;
      end
      if (bus2.sdram_rd_req) begin
        bus2.sdram_rd_data = mem2[rn % 16];
        bus2.sdram_rd_ack = 1'b1;
        rn++;
      end
    end
    chk("P1_done", {31'd0, done2}, 32'd1);
    chk("P1_words", wn + rn, 8);
    chk("P1_pass", {31'd0, pass2}, 32'd1);
    chk("P1_err_cnt", {16'd0, err_cnt2}, 32'd0);
    chk("P1_proto_err", {31'd0, proto2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_traffic_gen.md
Name: sdram_traffic_gen

Overview:
- Synthesizable, parametrised traffic generator/checker for sdram_ctrl; replaces the hand-written write/read request stimulus.
- Issues NUM_BURSTS write bursts, each immediately followed by a read-back burst of the same address range.
- Generates data patterns, compares read data on the fly, and reports pass/fail, error count and first failing address.
- Sits on the user side of sdram_ctrl in sys_clk (100 MHz) domain; usable in bench and on board.

Parameters:
- DATA_W, 16, SDRAM data width
- ADDR_W, 24, burst start address width
- BURST_LEN, 10, words per burst (1..1023), driven on wr_burst_len/rd_burst_len
- NUM_BURSTS, 4, write+read burst pairs per run (>=1)
- BASE_ADDR, 0, address of first burst
- PATTERN, 0, 0 = incrementing word index; 1 = bitwise-inverted word index
- CONTINUOUS, 0, 1 = restart automatically after DONE instead of waiting for start

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled in IDLE
- init_end  in  1  SDRAM initialisation complete
- sdram_wr_req  out  1  write request to controller
- sdram_wr_addr  out  ADDR_W  write burst start address
- wr_burst_len  out  10  constant BURST_LEN
- sdram_wr_data  out  DATA_W  write data word
- sdram_wr_ack  in  1  controller consumed current write word
- sdram_rd_req  out  1  read request to controller
- sdram_rd_addr  out  ADDR_W  read burst start address
- rd_burst_len  out  10  constant BURST_LEN
- sdram_rd_data  in  DATA_W  read data word
- sdram_rd_ack  in  1  sdram_rd_data valid
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid when done: err_cnt==0 and no protocol error
- err_cnt  out  16  mismatching read words, saturates at 16'hFFFF
- first_err_addr  out  ADDR_W  word address of first mismatch
- proto_err  out  1  sticky: ack received outside its phase

Behaviour:
- Reset: FSM=IDLE; every output 0 except wr_burst_len/rd_burst_len = BURST_LEN; all counters 0. Reset mid-burst abandons the burst immediately; no resume.
- FSM states: IDLE, WAIT_INIT, WRITE, WR_GAP, READ, RD_GAP, DONE.
- IDLE: start=1 -> WAIT_INIT; busy=1, done=0, err_cnt/first_err_addr/proto_err cleared, burst index b=0.
- WAIT_INIT: stay until init_end=1 -> WRITE.
- Word pattern for global word k = b*BURST_LEN + w (w = word in burst): PATTERN=0 -> k mod 2^DATA_W; PATTERN=1 -> ~k mod 2^DATA_W.
- Burst address: addr(b) = BASE_ADDR + b*BURST_LEN, truncated to ADDR_W (wraps).
- WRITE:
  - sdram_wr_req=1 (registered); sdram_wr_addr=addr(b).
  - sdram_wr_data=pattern(k), valid from first req cycle.
  - Each cycle wr_ack=1: w increments and data advances on the next edge.
  - On the BURST_LEN-th ack, wr_req drops on that same edge -> WR_GAP.
- WR_GAP: exactly 1 cycle, both reqs low -> READ.
- READ:
  - sdram_rd_req=1; sdram_rd_addr=addr(b).
  - Each cycle rd_ack=1: compare sdram_rd_data with pattern(k), then w++.
  - Mismatch: err_cnt++ (saturating). If first mismatch of run, latch first_err_addr = addr(b)+w.
  - On the BURST_LEN-th rd_ack, rd_req drops -> RD_GAP.
- RD_GAP: 1 cycle. If b==NUM_BURSTS-1 -> DONE, else b++, w=0 -> WRITE.
- DONE: busy=0, done=1, pass = (err_cnt==0 && !proto_err).
  - CONTINUOUS=0: start=1 -> WAIT_INIT (clears done and stats).
  - CONTINUOUS=1: -> WAIT_INIT after 1 cycle; stats clear.
- start while busy: ignored.
- wr_ack outside WRITE, or rd_ack outside READ: set proto_err; no counter change.
- wr_req and rd_req never high in the same cycle.
- init_end falling mid-run: ignored.

Test Plan:
- Defaults, model loopback, start pulse after init_end -> 4x(10 writes of 0..9 / 10..19 / ..., 10 reads at addr 0,10,20,30); done=1, pass=1, err_cnt=0; 80 acks total.
- Model forces bit0 flip on word 23 (burst 2, w=3) -> err_cnt=1, first_err_addr=23, pass=0.
- PATTERN=1, BURST_LEN=4, NUM_BURSTS=1 -> write data FFFF,FFFE,FFFD,FFFC; pass=1.
- wr_ack with gaps (ack every 3rd cycle) -> wr_data changes only after each ack; wr_req drops on the 10th ack; 1-cycle gap before rd_req rises.
- Spurious rd_ack during WRITE -> proto_err=1, pass=0 at done; data stream unaffected.
- sys_rst pulse mid-READ -> all outputs return to reset values asynchronously; new start reruns from address BASE_ADDR.
